// File: rtl/uart_rgb_cmd_parser.sv
// uart_rgb_cmd_parser
//   Parses ASCII LED commands popped from a UART RX FIFO and holds the
//   brightness level of NUM_LEDS RGB LEDs for the PWM drivers.
//   Command form: <c><n>[<h><l>]\n
//     c  = r/g/b
//     n  = '1'..NUM_LEDS
//     hl = two hex digits, case-insensitive
//   Without hex digits the command toggles the channel between 0 and
//   DEFAULT_LEVEL. When ECHO is set, every consumed byte is retransmitted.
// Ports
//   i_Clock, i_Reset_n         clock, async active-low reset
//   i_Data_Ready, i_Data       RX FIFO not-empty flag and head byte
//   o_Read_Data                1-cycle FIFO pop
//   i_Busy_TX                  UART TX busy (stalls the parser when ECHO=1)
//   o_Start, o_TX_Data         1-cycle TX start and echoed byte
//   o_Levels                   LED k colour c at [(k*3+c)*8 +: 8], r=0 g=1 b=2
//   o_Cmd_Done, o_Cmd_Error    1-cycle command applied / command dropped
module uart_rgb_cmd_parser #(
    parameter int         NUM_LEDS      = 3,
    parameter logic [7:0] DEFAULT_LEVEL = 8'h11,
    parameter bit         ECHO          = 1'b1
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_n,
    input  logic                    i_Data_Ready,
    input  logic [7:0]              i_Data,
    output logic                    o_Read_Data,
    input  logic                    i_Busy_TX,
    output logic                    o_Start,
    output logic [7:0]              o_TX_Data,
    output logic [NUM_LEDS*24-1:0]  o_Levels,
    output logic                    o_Cmd_Done,
    output logic                    o_Cmd_Error
);
    localparam int         NFLD    = NUM_LEDS * 3;
    localparam int         FLD_W   = (NFLD > 1) ? $clog2(NFLD) : 1;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] LED_MAX = 8'(8'h30 + NUM_LEDS);

    typedef enum logic [2:0] {
        S_COLOUR, S_LED, S_HEX_HI, S_HEX_LO, S_NL, S_DISCARD
    } state_t;

    state_t                     state;
    logic                       pause;
    logic [1:0]                 col_q;
    logic [3:0]                 led_q;
    logic [3:0]                 hi_q;
    logic [3:0]                 lo_q;
    logic [NFLD-1:0][7:0]       levels;
    logic                       take;
    logic [FLD_W-1:0]           idx;
    logic [4:0]                 hex;

    // {valid, nibble}; letters map via low nibble + 9 ('a'/'A' low nibble is 1)
    function automatic logic [4:0] hex_dec(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39)
            return {1'b1, b[3:0]};
        else if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46))
            return {1'b1, 4'(b[3:0] + 4'd9)};
        else
            return 5'd0;
    endfunction

    // The pause cycle after every take covers the registered pop: the FIFO
    // head only advances at the end of the cycle o_Read_Data is high.
    assign take     = i_Data_Ready && !pause && (!ECHO || !i_Busy_TX);
    assign idx      = FLD_W'(int'(led_q) * 3 + int'(col_q));
    assign hex      = hex_dec(i_Data);
    assign o_Levels = levels;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= S_COLOUR;
            pause       <= 1'b0;
            col_q       <= 2'd0;
            led_q       <= 4'd0;
            hi_q        <= 4'd0;
            lo_q        <= 4'd0;
            levels      <= '0;
            o_Read_Data <= 1'b0;
            o_Start     <= 1'b0;
            o_TX_Data   <= 8'd0;
            o_Cmd_Done  <= 1'b0;
            o_Cmd_Error <= 1'b0;
        end else begin
            o_Read_Data <= 1'b0;
            o_Start     <= 1'b0;
            o_Cmd_Done  <= 1'b0;
            o_Cmd_Error <= 1'b0;
            pause       <= 1'b0;
            if (take) begin
                o_Read_Data <= 1'b1;
                pause       <= 1'b1;
                if (ECHO) begin
                    o_Start   <= 1'b1;
                    o_TX_Data <= i_Data;
                end
                if (i_Data != CH_CR) begin
                    case (state)
                        S_COLOUR: begin
                            if (i_Data == "r")      begin col_q <= 2'd0; state <= S_LED; end
                            else if (i_Data == "g") begin col_q <= 2'd1; state <= S_LED; end
                            else if (i_Data == "b") begin col_q <= 2'd2; state <= S_LED; end
                            else if (i_Data != CH_LF) state <= S_DISCARD;
                        end
                        S_LED: begin
                            if (i_Data >= "1" && i_Data <= LED_MAX) begin
                                led_q <= 4'(i_Data[3:0] - 4'd1);
                                state <= S_HEX_HI;
                            end else
                                state <= S_DISCARD;
                        end
                        S_HEX_HI: begin
                            if (i_Data == CH_LF) begin
                                levels[idx] <= (levels[idx] != 8'd0) ? 8'd0 : DEFAULT_LEVEL;
                                o_Cmd_Done  <= 1'b1;
                                state       <= S_COLOUR;
                            end else if (hex[4]) begin
                                hi_q  <= hex[3:0];
                                state <= S_HEX_LO;
                            end else
                                state <= S_DISCARD;
                        end
                        S_HEX_LO: begin
                            if (hex[4]) begin
                                lo_q  <= hex[3:0];
                                state <= S_NL;
                            end else
                                state <= S_DISCARD;
                        end
                        S_NL: begin
                            if (i_Data == CH_LF) begin
                                levels[idx] <= {hi_q, lo_q};
                                o_Cmd_Done  <= 1'b1;
                                state       <= S_COLOUR;
                            end else
                                state <= S_DISCARD;
                        end
                        S_DISCARD: begin
                            if (i_Data == CH_LF) begin
                                o_Cmd_Error <= 1'b1;
                                state       <= S_COLOUR;
                            end
                        end
                        default: state <= S_COLOUR;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rgb_cmd_parser.sv
// Scoreboard bench for uart_rgb_cmd_parser (NUM_LEDS=3, ECHO=1).
// A queue-backed FIFO model feeds the parser; expected command outcomes and
// echoed bytes are queued as stimulus is issued and popped on DUT strobes.
module tb_uart_rgb_cmd_parser;
    localparam int LW = 72;

    typedef struct {
        bit            err;
        logic [LW-1:0] lv;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_Data_Ready = 1'b0;
    logic [7:0]    i_Data = 8'd0;
    logic          i_Busy_TX = 1'b0;
    logic          o_Read_Data, o_Start, o_Cmd_Done, o_Cmd_Error;
    logic [7:0]    o_TX_Data;
    logic [LW-1:0] o_Levels;

    int            n_tests = 0;
    int            n_fail = 0;
    logic [7:0]    fifo[$];
    logic [7:0]    echoq[$];
    exp_t          expq[$];
    logic [LW-1:0] mdl = '0;
    int            cnt_rd = 0;
    int            cnt_st = 0;
    logic          prev_rd = 1'b0;

    uart_rgb_cmd_parser #(.NUM_LEDS(3), .DEFAULT_LEVEL(8'h11), .ECHO(1'b1)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_Data_Ready(i_Data_Ready), .i_Data(i_Data), .o_Read_Data(o_Read_Data),
        .i_Busy_TX(i_Busy_TX), .o_Start(o_Start), .o_TX_Data(o_TX_Data),
        .o_Levels(o_Levels), .o_Cmd_Done(o_Cmd_Done), .o_Cmd_Error(o_Cmd_Error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model + monitor, sampled 1 time unit after the active edge
    initial begin
        exp_t e;
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #1;
            if (o_Read_Data) begin
                chk("rd_adj", {127'd0, prev_rd}, 128'd0);
                cnt_rd++;
                if (fifo.size() > 0) void'(fifo.pop_front());
                else chk("pop_empty", 128'd1, 128'd0);
            end
            prev_rd = o_Read_Data;
            if (o_Start) begin
                cnt_st++;
                if (echoq.size() > 0) begin
                    b = echoq.pop_front();
                    chk("echo", {120'd0, o_TX_Data}, {120'd0, b});
                end else
                    chk("echo_unexp", 128'd1, 128'd0);
            end
            if (o_Cmd_Done || o_Cmd_Error) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("kind_err", {127'd0, o_Cmd_Error}, {127'd0, e.err});
                    chk("kind_done", {127'd0, o_Cmd_Done}, {127'd0, !e.err});
                    chk("levels", {56'd0, o_Levels}, {56'd0, e.lv});
                end else
                    chk("pulse_unexp", {126'd0, o_Cmd_Done, o_Cmd_Error}, 128'd0);
            end
            i_Data_Ready = (fifo.size() > 0);
            i_Data = (fifo.size() > 0) ? fifo[0] : 8'd0;
        end
    end

    task automatic send_raw(input string s);
        for (int i = 0; i < s.len(); i++) begin
            fifo.push_back(s[i]);
            echoq.push_back(s[i]);
        end
    endtask

    // fld = led*3 + colour; err commands leave the model untouched
    task automatic send_cmd(input string s, input bit err, input int fld, input logic [7:0] v);
        exp_t e;
        send_raw(s);
        if (!err) mdl[fld*8 +: 8] = v;
        e.err = err;
        e.lv = mdl;
        expq.push_back(e);
    endtask

    task automatic drain();
        int i = 0;
        while ((fifo.size() > 0 || expq.size() > 0 || echoq.size() > 0) && i < 3000) begin
            @(posedge clk);
            i++;
        end
        repeat (4) @(posedge clk);
        chk("drain_timeout", {127'd0, i >= 3000}, 128'd0);
    endtask

    initial begin
        int r0, s0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_levels", {56'd0, o_Levels}, 128'd0);
        chk("rst_done", {127'd0, o_Cmd_Done}, 128'd0);
        chk("rst_err", {127'd0, o_Cmd_Error}, 128'd0);
        chk("rst_rd", {127'd0, o_Read_Data}, 128'd0);
        chk("rst_start", {127'd0, o_Start}, 128'd0);
        chk("rst_txd", {120'd0, o_TX_Data}, 128'd0);
        @(negedge clk) rst_n = 1'b1;

        // toggle on, toggle off
        send_cmd("r1\n", 1'b0, 0, 8'h11);
        send_cmd("r1\n", 1'b0, 0, 8'h00);
        // explicit hex, both cases
        send_cmd("g3A5\n", 1'b0, 7, 8'hA5);
        send_cmd("b2ff\n", 1'b0, 5, 8'hFF);
        // malformed commands, then recovery
        send_cmd("r4\n", 1'b1, 0, 8'h00);
        send_cmd("x1\n", 1'b1, 0, 8'h00);
        send_cmd("r1G0\n", 1'b1, 0, 8'h00);
        send_cmd("r0\n", 1'b1, 0, 8'h00);
        send_cmd("b1\n", 1'b0, 2, 8'h11);
        drain();

        // TX busy stalls with a byte pending
        @(negedge clk);
        i_Busy_TX = 1'b1;
        send_raw("r");
        r0 = cnt_rd;
        s0 = cnt_st;
        repeat (100) @(posedge clk);
        #1;
        chk("busy_no_pop", 128'(cnt_rd - r0), 128'd0);
        chk("busy_no_start", 128'(cnt_st - s0), 128'd0);
        chk("busy_fifo_kept", 128'(fifo.size()), 128'd1);
        @(negedge clk);
        i_Busy_TX = 1'b0;
        send_cmd("1\n", 1'b0, 0, 8'h11);
        drain();

        // CR ignored, empty line produces no pulse
        send_raw("\n");
        send_cmd("r1\015\n", 1'b0, 0, 8'h00);
        send_cmd("g1\015\n", 1'b0, 1, 8'h11);
        drain();

        // reset mid-command
        send_raw("g2");
        drain();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_levels", {56'd0, o_Levels}, 128'd0);
        mdl = '0;
        @(negedge clk) rst_n = 1'b1;
        send_cmd("g2\n", 1'b0, 4, 8'h11);
        drain();
        chk("final_levels", {56'd0, o_Levels}, {56'd0, mdl});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
